// File: rtl/minmax_sequencer_pkg.sv
// Shared definitions for the min/max burst sequencer: FSM state encoding and parameter defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package minmax_sequencer_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/minmax_sequencer_cmp_unit.sv
// Purely combinational unsigned compare of x against y, producing eq/gt/lt together.
// Latency: 0 cycles (combinational).
// Backpressure: none; no handshake.
// Ports: x, y operands; eq (x==y), gt (x>y), lt (x<y).
module cmp_unit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  assign eq = (x == y);
  assign gt = (x > y);
  assign lt = (x < y);

endmodule

// File: rtl/minmax_sequencer.sv
// Burst min/max/equality sequencer: accepts len samples and reports max (first index), min and count equal to sample 0.
// Latency: done pulses one cycle after the last transfer edge (empty batch: one cycle after start).
// Backpressure: in_ready is registered; high only in ACC, dropped right after the final transfer; in_valid gaps stall indefinitely.
// Ports: clk, rst_n (async active-low); start/len (batch request, sampled in IDLE); in_valid/in_data/in_ready (sample stream);
//        busy (ACC or DONE), done (1-cycle pulse); max_out, max_idx, min_out, eq_cnt (results, held until the next batch).
module minmax_sequencer
  import minmax_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] max_out,
  output logic [CNT_W-1:0] max_idx,
  output logic [WIDTH-1:0] min_out,
  output logic [CNT_W-1:0] eq_cnt
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] len_q, len_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [WIDTH-1:0] ref_q, ref_nxt;
  logic [WIDTH-1:0] max_nxt, min_nxt;
  logic [CNT_W-1:0] idx_nxt, eq_nxt;
  logic             ready_nxt, busy_nxt, done_nxt;

  logic xfer;
  logic max_eq, max_gt, max_lt;
  logic min_eq, min_gt, min_lt;
  logic ref_eq, ref_gt, ref_lt;

  assign xfer = in_valid & in_ready;

  cmp_unit #(.WIDTH(WIDTH)) u_cmp_max (.x(in_data), .y(max_out), .eq(max_eq), .gt(max_gt), .lt(max_lt));
  cmp_unit #(.WIDTH(WIDTH)) u_cmp_min (.x(in_data), .y(min_out), .eq(min_eq), .gt(min_gt), .lt(min_lt));
  cmp_unit #(.WIDTH(WIDTH)) u_cmp_ref (.x(in_data), .y(ref_q),   .eq(ref_eq), .gt(ref_gt), .lt(ref_lt));

  // Only gt of the max compare, lt of the min compare and eq of the reference compare steer the datapath.
  logic unused_cmp;
  assign unused_cmp = ^{max_eq, max_lt, min_eq, min_gt, ref_gt, ref_lt};

  always_comb begin
    state_nxt = state;
    len_nxt   = len_q;
    cnt_nxt   = cnt_q;
    ref_nxt   = ref_q;
    max_nxt   = max_out;
    idx_nxt   = max_idx;
    min_nxt   = min_out;
    eq_nxt    = eq_cnt;
    ready_nxt = in_ready;
    busy_nxt  = busy;
    done_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          busy_nxt = 1'b1;
          if (len != '0) begin
            len_nxt   = len;
            cnt_nxt   = '0;
            ready_nxt = 1'b1;
            state_nxt = ACC;
          end else begin
            // Empty batch completes immediately with zeroed results.
            max_nxt   = '0;
            idx_nxt   = '0;
            min_nxt   = '0;
            eq_nxt    = '0;
            done_nxt  = 1'b1;
            state_nxt = DONE;
          end
        end
      end

      ACC: begin
        if (xfer) begin
          if (cnt_q == '0) begin
            // First sample seeds every tracker and becomes the equality reference.
            max_nxt = in_data;
            idx_nxt = '0;
            min_nxt = in_data;
            eq_nxt  = CNT_W'(1);
            ref_nxt = in_data;
          end else begin
            // Strict greater-than keeps the earliest index on a tie.
            if (max_gt) begin
              max_nxt = in_data;
              idx_nxt = cnt_q;
            end
            if (min_lt) min_nxt = in_data;
            if (ref_eq) eq_nxt = eq_cnt + CNT_W'(1);
          end
          cnt_nxt = cnt_q + CNT_W'(1);
          if (cnt_q == len_q - CNT_W'(1)) begin
            ready_nxt = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = DONE;
          end
        end
      end

      DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end

      default: begin
        ready_nxt = 1'b0;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      ref_q    <= '0;
      max_out  <= '0;
      max_idx  <= '0;
      min_out  <= '0;
      eq_cnt   <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      len_q    <= len_nxt;
      cnt_q    <= cnt_nxt;
      ref_q    <= ref_nxt;
      max_out  <= max_nxt;
      max_idx  <= idx_nxt;
      min_out  <= min_nxt;
      eq_cnt   <= eq_nxt;
      in_ready <= ready_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: doc/minmax_sequencer.md
Name: minmax_sequencer

Overview:
- Sequential controller that drives a shared 4-bit compare datapath (equality, greater-than, less-than) over a burst of operands.
- Accepts a batch of `len` samples over a valid/ready stream.
- Tracks the running maximum, its index, the running minimum, and how many samples equal the first sample.
- Sits between an operand source (register file or test stimulus) and the ALU result mux; reports results with a one-cycle done pulse.

Parameters:
- WIDTH, 4, operand width in bits
- CNT_W, 4, batch-length/index counter width; max batch length is 2^CNT_W-1 = 15

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a batch; sampled only in IDLE
- len  input  CNT_W  number of samples in the batch; latched on accepted start
- in_valid  input  1  in_data is valid this cycle
- in_data  input  WIDTH  operand sample
- in_ready  output  1  block accepts a sample this cycle (registered)
- busy  output  1  high in ACC and DONE
- done  output  1  one-cycle pulse: results are final
- max_out  output  WIDTH  largest sample of the batch
- max_idx  output  CNT_W  index (0-based) of the first occurrence of the maximum
- min_out  output  WIDTH  smallest sample of the batch
- eq_cnt  output  CNT_W  count of samples equal to sample 0, including sample 0 itself

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE.
  - in_ready, busy, done, max_out, max_idx, min_out and eq_cnt are all 0.
  - Reset takes effect immediately, including mid-batch; the partial batch is discarded and no done is produced.
- States: IDLE, ACC, DONE. All outputs are registered.
- IDLE:
  - start=1 and len!=0: latch len, clear the sample counter, go to ACC. in_ready=1 and busy=1 from the next cycle.
  - start=1 and len==0: go to DONE with all results forced to 0 (empty-batch completion).
  - start=0: stay in IDLE. Results hold their last values.
- Transfer occurs on an edge where in_valid=1 and in_ready=1. in_valid while in_ready=0 is ignored and in_data is not captured.
- ACC, first transfer (cnt==0):
  - max_out=min_out=in_data, max_idx=0, eq_cnt=1.
  - Latch in_data as the reference for the equality comparison.
- ACC, later transfers (unsigned compares):
  - in_data>max_out: max_out=in_data, max_idx=cnt.
  - A tie with max_out keeps the earlier index.
  - in_data<min_out: min_out=in_data.
  - in_data==reference: eq_cnt+1.
  - cnt+1 after every transfer.
- Burst end:
  - The transfer with cnt==len-1 moves the FSM to DONE.
  - in_ready is 0 from the following cycle, so there is no back-to-back over-accept.
- DONE:
  - Exactly one cycle with done=1; then IDLE, with busy falling together with done.
  - Latency is one cycle from the last transfer edge to done high.
- Results:
  - Values are valid while done=1 and stay stable until the next accepted start.
  - Intermediate values are visible during ACC but are not guaranteed meaningful.
- start in ACC or DONE is ignored. No abort input exists.
- in_valid gaps stall ACC indefinitely with no timeout.
- Counter cannot overflow because len ≤ 2^CNT_W-1.

Decomposition:
- Shared package holds the FSM state encoding (IDLE=2'd0, ACC=2'd1, DONE=2'd2) and the WIDTH/CNT_W defaults.
- One sub-module, cmp_unit: a purely combinational 4-bit x/y compare that returns eq, gt and lt in one instance.
- Instantiate cmp_unit three times: in_data vs max_out, in_data vs min_out, and in_data vs reference.
- FSM, counters and result registers live in the top module.

Test Plan:
- Reset mid-batch: start len=5, send 2 samples, pulse rst_n low → all outputs 0 at once, state IDLE, no done; a new start len=1 with data 7 → done, max=min=7, idx=0, eq_cnt=1.
- Basic batch, in_valid held high: len=4, data 3,9,1,9 → done one cycle after the 4th transfer; max=9, max_idx=1 (tie keeps earlier), min=1, eq_cnt=1.
- Equality count with stalls: len=5, data 6,6,2,6,15 with in_valid low 3 cycles between samples 2 and 3 → max=15, idx=4, min=2, eq_cnt=3; in_ready stays 1 through the stalls.
- Empty batch and ignored start: start with len=0 → done one cycle later, all results 0, in_ready never 1. A start pulse during ACC of a len=3 batch does not restart it; results cover the original 3 samples only.
- Extremes: len=15, all samples 0 → max=min=0, idx=0, eq_cnt=15. Then len=2, data 15,0 → max=15, idx=0, min=0, eq_cnt=1; in_ready=0 the cycle after the 2nd transfer even with in_valid held high.
